// File: rtl/irq_ctrl_if.sv
// MMIO register-access bus between the core's load/store path and irq_ctrl.
// The core side is the master; irq_ctrl answers reads one cycle later.
interface irq_ctrl_if #(
   parameter int ADDR_W = 5
);
   logic              mmio_valid;
   logic              mmio_we;
   logic [ADDR_W-1:0] mmio_addr;
   logic [31:0]       mmio_wdata;
   logic [31:0]       mmio_rdata;
   logic              mmio_rvalid;

   modport master (
      output mmio_valid, mmio_we, mmio_addr, mmio_wdata,
      input  mmio_rdata, mmio_rvalid
   );

   modport slave (
      input  mmio_valid, mmio_we, mmio_addr, mmio_wdata,
      output mmio_rdata, mmio_rvalid
   );
endinterface

// File: rtl/irq_ctrl.sv
// Machine-mode interrupt source: 64-bit mtime/mtimecmp, msip, and a held trap request.
// Optional external interrupt input is enabled by defining IRQ_CTRL_EXT_IRQ_EN.
module irq_ctrl #(
   parameter int TICK_DIV = 1,
   parameter int ADDR_W   = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   irq_ctrl_if.slave   mmio,
   input  logic        mie,
   output logic        irq_req,
   output logic [31:0] irq_cause,
   input  logic        irq_ack,
   input  logic        mret,
   output logic        mtip
`ifdef IRQ_CTRL_EXT_IRQ_EN
   ,
   input  logic        ext_irq
`endif
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

   localparam logic [ADDR_W-3:0] W_MSIP  = (ADDR_W-2)'(0);
   localparam logic [ADDR_W-3:0] W_CMPLO = (ADDR_W-2)'(2);
   localparam logic [ADDR_W-3:0] W_CMPHI = (ADDR_W-2)'(3);
   localparam logic [ADDR_W-3:0] W_TLO   = (ADDR_W-2)'(4);
   localparam logic [ADDR_W-3:0] W_THI   = (ADDR_W-2)'(5);

   typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

   state_t        state_q;
   logic [63:0]   mtime_q, mtime_d;
   logic [63:0]   mtimecmp_q, mtimecmp_d;
   logic          msip_q, msip_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          rvalid_q;
   logic          req_q;
   logic [31:0]   cause_q;
   logic [ADDR_W-3:0] word;
   logic          wr, rd;
   logic          ext_pend, pend_any;
   logic [3:0]    win_code;
   logic          unused_addr_lsb;

   assign word            = mmio.mmio_addr[ADDR_W-1:2];
   assign unused_addr_lsb = ^mmio.mmio_addr[1:0];
   assign wr              = mmio.mmio_valid & mmio.mmio_we;
   assign rd              = mmio.mmio_valid & ~mmio.mmio_we;

   assign mtip             = (mtime_q >= mtimecmp_q);
   assign irq_req          = req_q;
   assign irq_cause        = cause_q;
   assign mmio.mmio_rdata  = rdata_q;
   assign mmio.mmio_rvalid = rvalid_q;

`ifdef IRQ_CTRL_EXT_IRQ_EN
   logic [1:0] ext_sync_q;

   // Two-flop synchroniser for the asynchronous external level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ext_sync_q <= 2'b00;
      end else begin
         ext_sync_q <= {ext_sync_q[0], ext_irq};
      end
   end
   assign ext_pend = ext_sync_q[1];
`else
   assign ext_pend = 1'b0;
`endif

   // A write to either mtime half replaces the tick for that cycle and leaves the other half alone.
   always_comb begin
      presc_d    = (presc_q == PRE_MAX) ? '0 : presc_q + 1'b1;
      mtime_d    = (presc_q == PRE_MAX) ? mtime_q + 64'd1 : mtime_q;
      mtimecmp_d = mtimecmp_q;
      msip_d     = msip_q;
      if (wr) begin
         case (word)
            W_MSIP:  msip_d             = mmio.mmio_wdata[0];
            W_CMPLO: mtimecmp_d[31:0]   = mmio.mmio_wdata;
            W_CMPHI: mtimecmp_d[63:32]  = mmio.mmio_wdata;
            W_TLO:   mtime_d            = {mtime_q[63:32], mmio.mmio_wdata};
            W_THI:   mtime_d            = {mmio.mmio_wdata, mtime_q[31:0]};
            default: ;
         endcase
      end
   end

   always_comb begin
      rdata_d = 32'd0;
      case (word)
         W_MSIP:  rdata_d = {31'd0, msip_q};
         W_CMPLO: rdata_d = mtimecmp_q[31:0];
         W_CMPHI: rdata_d = mtimecmp_q[63:32];
         W_TLO:   rdata_d = mtime_q[31:0];
         W_THI:   rdata_d = mtime_q[63:32];
         default: rdata_d = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mtime_q    <= 64'd0;
         mtimecmp_q <= {64{1'b1}};
         msip_q     <= 1'b0;
         presc_q    <= '0;
         rdata_q    <= 32'd0;
         rvalid_q   <= 1'b0;
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         msip_q     <= msip_d;
         presc_q    <= presc_d;
         rvalid_q   <= rd;
         if (rd) begin
            rdata_q <= rdata_d;
         end
      end
   end

   // Fixed priority: external (11) over software (3) over timer (7).
   always_comb begin
      pend_any = ext_pend | msip_q | mtip;
      if (ext_pend) begin
         win_code = 4'd11;
      end else if (msip_q) begin
         win_code = 4'd3;
      end else begin
         win_code = 4'd7;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         cause_q <= 32'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (mie && pend_any) begin
                  cause_q <= {1'b1, 27'd0, win_code};
                  req_q   <= 1'b1;
                  state_q <= REQ;
               end
            end
            REQ: begin
               if (irq_ack) begin
                  req_q   <= 1'b0;
                  state_q <= SVC;
               end
            end
            SVC: begin
               if (mret) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               req_q   <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Randomised scoreboard bench for irq_ctrl against a behavioural model of the timer,
// MMIO map and trap request/service protocol.
module tb_irq_ctrl;

   localparam int TB_TICK = 3;
`ifdef IRQ_CTRL_EXT_IRQ_EN
   localparam bit EXT_EN = 1'b1;
`else
   localparam bit EXT_EN = 1'b0;
`endif

   typedef struct packed {
      logic        req;
      logic        tip;
      logic        rv;
      logic [31:0] cause;
   } cyc_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mie, irq_ack, mret;
   logic        irq_req, mtip;
   logic [31:0] irq_cause;
`ifdef IRQ_CTRL_EXT_IRQ_EN
   logic        ext_irq;
`endif

   irq_ctrl_if #(.ADDR_W(5)) bus ();

   irq_ctrl #(.TICK_DIV(TB_TICK), .ADDR_W(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mmio      (bus),
      .mie       (mie),
      .irq_req   (irq_req),
      .irq_cause (irq_cause),
      .irq_ack   (irq_ack),
      .mret      (mret),
      .mtip      (mtip)
`ifdef IRQ_CTRL_EXT_IRQ_EN
      ,
      .ext_irq   (ext_irq)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic [31:0] rdQ[$];
   logic [31:0] causeQ[$];
   cyc_t        cycQ[$];

   longint unsigned mTime, mCmp;
   bit          mMsip, eS1, eS2;
   int          mPresc, mState;
   logic [31:0] mCause;
   bit          prevReq = 1'b0;
   cyc_t        monE;

   task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] readModel(input logic [4:0] a);
      case (a[4:2])
         3'd0:    return {31'd0, mMsip};
         3'd2:    return mCmp[31:0];
         3'd3:    return mCmp[63:32];
         3'd4:    return mTime[31:0];
         3'd5:    return mTime[63:32];
         default: return 32'd0;
      endcase
   endfunction

   task automatic modelReset();
      mTime  = 64'd0;
      mCmp   = 64'hFFFF_FFFF_FFFF_FFFF;
      mMsip  = 1'b0;
      mPresc = 0;
      mState = 0;
      mCause = 32'd0;
      eS1    = 1'b0;
      eS2    = 1'b0;
   endtask

   // One clock: drive at negedge, predict the effect of the coming posedge, end at next negedge.
   task automatic applyStimulus(input bit v, input bit we, input logic [4:0] a, input logic [31:0] wd,
                                input bit ie, input bit ack, input bit mr, input bit ex);
      cyc_t       e;
      bit         tip, any, exEff, timeWr;
      logic [3:0] code;
      bus.mmio_valid = v;
      bus.mmio_we    = we;
      bus.mmio_addr  = a;
      bus.mmio_wdata = wd;
      mie            = ie;
      irq_ack        = ack;
      mret           = mr;
      exEff          = EXT_EN ? ex : 1'b0;
`ifdef IRQ_CTRL_EXT_IRQ_EN
      ext_irq        = ex;
`endif
      tip = (mTime >= mCmp);
      any = 1'b1;
      if (eS2)        code = 4'd11;
      else if (mMsip) code = 4'd3;
      else if (tip)   code = 4'd7;
      else begin
         code = 4'd0;
         any  = 1'b0;
      end
      if (v && !we) rdQ.push_back(readModel(a));
      case (mState)
         0: if (ie && any) begin
               mCause = {1'b1, 27'd0, code};
               causeQ.push_back(mCause);
               mState = 1;
            end
         1: if (ack) mState = 2;
         default: if (mr) mState = 0;
      endcase
      timeWr = v && we && (a[4:2] == 3'd4 || a[4:2] == 3'd5);
      if (v && we) begin
         case (a[4:2])
            3'd0: mMsip = wd[0];
            3'd2: mCmp  = {mCmp[63:32], wd};
            3'd3: mCmp  = {wd, mCmp[31:0]};
            3'd4: mTime = {mTime[63:32], wd};
            3'd5: mTime = {wd, mTime[31:0]};
            default: ;
         endcase
      end
      if (!timeWr && mPresc == TB_TICK - 1) mTime = mTime + 1;
      mPresc = (mPresc + 1) % TB_TICK;
      eS2 = eS1;
      eS1 = exEff;
      e.req   = (mState == 1);
      e.tip   = (mTime >= mCmp);
      e.rv    = v && !we;
      e.cause = mCause;
      cycQ.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n, input bit ie);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 5'h00, 32'd0, ie, 0, 0, 0);
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input bit ie);
      applyStimulus(1, 1, a, d, ie, 0, 0, 0);
   endtask

   task automatic rdReg(input logic [4:0] a, input bit ie);
      applyStimulus(1, 0, a, 32'd0, ie, 0, 0, 0);
   endtask

   task automatic waitReq(input int budget, input bit ie, input string nm);
      for (int i = 0; i < budget && mState != 1; i++) idle(1, ie);
      checks++;
      if (mState != 1) begin
         failures++;
         $display("[TB] FAIL %s timeout actual=no_request expected=request", nm);
      end
   endtask

   task automatic doReset();
      #2 rst_n = 1'b0;
      modelReset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      checkOutput("rst_irq_req", {31'd0, irq_req}, 32'd0);
      checkOutput("rst_irq_cause", irq_cause, 32'd0);
      checkOutput("rst_rvalid", {31'd0, bus.mmio_rvalid}, 32'd0);
      checkOutput("rst_rdata", bus.mmio_rdata, 32'd0);
      checkOutput("rst_mtip", {31'd0, mtip}, 32'd0);
   endtask

   // Monitor: per-cycle levels, first-cycle cause, and read data as it appears.
   always @(posedge clk) begin
      #1;
      if (cycQ.size() > 0) begin
         monE = cycQ.pop_front();
         checkOutput("irq_req", {31'd0, irq_req}, {31'd0, monE.req});
         checkOutput("mtip", {31'd0, mtip}, {31'd0, monE.tip});
         checkOutput("rvalid", {31'd0, bus.mmio_rvalid}, {31'd0, monE.rv});
         if (monE.req) checkOutput("cause_held", irq_cause, monE.cause);
      end
      if (irq_req && !prevReq) begin
         if (causeQ.size() == 0) checkOutput("cause_unexpected_req", {31'd0, irq_req}, 32'd0);
         else checkOutput("cause_new", irq_cause, causeQ.pop_front());
      end
      prevReq = irq_req;
      if (bus.mmio_rvalid) begin
         if (rdQ.size() == 0) checkOutput("rvalid_unexpected", 32'd1, 32'd0);
         else checkOutput("rdata", bus.mmio_rdata, rdQ.pop_front());
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [4:0]  a;
      logic [31:0] wd;
      bit          v, we;
      rst_n = 1'b0;
      bus.mmio_valid = 0; bus.mmio_we = 0; bus.mmio_addr = '0; bus.mmio_wdata = '0;
      mie = 0; irq_ack = 0; mret = 0;
`ifdef IRQ_CTRL_EXT_IRQ_EN
      ext_irq = 0;
`endif
      modelReset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      checkOutput("init_irq_req", {31'd0, irq_req}, 32'd0);
      checkOutput("init_mtip", {31'd0, mtip}, 32'd0);

      for (int i = 0; i < 8; i++) rdReg(5'h10, 0);
      doReset();
      for (int i = 0; i < 6; i++) rdReg(5'h10, 0);
      rdReg(5'h08, 0); rdReg(5'h0C, 0); rdReg(5'h00, 0); rdReg(5'h04, 0); rdReg(5'h18, 0);

      $display("[TB] timer interrupt");
      wr(5'h0C, 32'd0, 0);
      wr(5'h08, 32'd20, 1);
      waitReq(200, 1, "timer_req");
      idle(3, 1);
      applyStimulus(0, 0, 5'h00, 0, 1, 1, 0, 0);
      idle(2, 1);
      applyStimulus(0, 0, 5'h00, 0, 1, 0, 1, 0);
      waitReq(5, 1, "timer_rereq");

      $display("[TB] priority");
      applyStimulus(0, 0, 5'h00, 0, 1, 1, 0, 0);
      wr(5'h00, 32'd1, 1);
      applyStimulus(0, 0, 5'h00, 0, 1, 0, 1, 0);
      waitReq(5, 1, "soft_req");
      applyStimulus(0, 0, 5'h00, 0, 1, 1, 0, 0);
      wr(5'h00, 32'd0, 1);
      applyStimulus(0, 0, 5'h00, 0, 1, 0, 1, 0);
      waitReq(5, 1, "timer_after_soft");
      applyStimulus(0, 0, 5'h00, 0, 1, 1, 0, 0);
      wr(5'h0C, 32'hFFFF_FFFF, 1);
      applyStimulus(0, 0, 5'h00, 0, 1, 0, 1, 0);
      idle(3, 1);

      $display("[TB] masking and hold");
      wr(5'h00, 32'd1, 0);
      idle(5, 0);
      idle(1, 1);
      wr(5'h00, 32'd0, 0);
      idle(3, 0);
      applyStimulus(0, 0, 5'h00, 0, 0, 1, 0, 0);
      applyStimulus(0, 0, 5'h00, 0, 0, 0, 1, 0);

      $display("[TB] mtime wrap and write");
      wr(5'h14, 32'hFFFF_FFFF, 0);
      wr(5'h10, 32'hFFFF_FFFE, 0);
      for (int i = 0; i < 6; i++) begin
         rdReg(5'h10, 0);
         rdReg(5'h14, 0);
      end
      for (int i = 0; i < TB_TICK && mPresc != TB_TICK - 1; i++) idle(1, 0);
      wr(5'h10, 32'h0000_1234, 0);
      rdReg(5'h10, 0);
      rdReg(5'h14, 0);

`ifdef IRQ_CTRL_EXT_IRQ_EN
      $display("[TB] external interrupt");
      wr(5'h00, 32'd1, 0);
      applyStimulus(0, 0, 5'h00, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 5'h00, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 5'h00, 0, 1, 0, 0, 0);
      checkOutput("ext_cause", irq_cause, 32'h8000_000B);
      applyStimulus(0, 0, 5'h00, 0, 1, 1, 0, 0);
      wr(5'h00, 32'd0, 1);
      applyStimulus(0, 0, 5'h00, 0, 1, 0, 1, 0);
`endif

      $display("[TB] random phase");
      for (int i = 0; i < 800; i++) begin
         if (i == 400) doReset();
         v  = ($urandom % 3) == 0;
         we = $urandom % 2;
         a  = {3'($urandom % 8), 2'b00};
         case (a[4:2])
            3'd0:    wd = $urandom % 2;
            3'd2:    wd = mTime[31:0] + $urandom_range(0, 40);
            3'd3:    wd = ($urandom % 2) ? mTime[63:32] : 32'hFFFF_FFFF;
            3'd4:    wd = mCmp[31:0] - $urandom_range(0, 40);
            3'd5:    wd = mTime[63:32];
            default: wd = $urandom;
         endcase
         applyStimulus(v, we, a, wd, ($urandom % 4) != 0, ($urandom % 3) == 0,
                       ($urandom % 5) == 0, ($urandom % 6) == 0);
      end
      idle(3, 0);
      checkOutput("rdq_drained", rdQ.size(), 32'd0);
      checkOutput("causeq_drained", causeQ.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
